// File: rtl/piso_ser.sv
// Parallel-in serial-out serializer with valid/ready word intake, MSB first.
// Define PISO_PARITY_EN to append an even-parity bit after din[0].
module piso_ser #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
    localparam int unsigned FRAME_LEN = WIDTH;
`endif
    localparam int unsigned CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
        $error("piso_ser: WIDTH must be in 2..32");
    end

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [FRAME_LEN-1:0]   r_shift;
    logic [FRAME_LEN-1:0]   w_shift_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [FRAME_LEN-1:0]   w_load;
    logic                   w_last;
    logic                   w_accept;

    // Parity is folded into the loaded frame so later din changes cannot touch it.
`ifdef PISO_PARITY_EN
    assign w_load = {din, ^din};
`else
    assign w_load = din;
`endif

    assign w_last    = (r_state == StShift) && (r_cnt == LAST_CNT);
    assign din_ready = (r_state == StIdle) || w_last;
    assign w_accept  = din_valid && din_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = StShift;
                    w_shift_nxt = w_load;
                    w_cnt_nxt   = '0;
                end
            end
            StShift: begin
                if (w_last) begin
                    if (w_accept) begin
                        w_shift_nxt = w_load;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = StIdle;
                        w_shift_nxt = '0;
                        w_cnt_nxt   = '0;
                    end
                end else begin
                    w_shift_nxt = {r_shift[FRAME_LEN-2:0], 1'b0};
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_shift_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs decode from state only, so reset clears them without waiting for a clock.
    assign so_valid = (r_state == StShift);
    assign busy     = so_valid;
    assign so       = so_valid && r_shift[FRAME_LEN-1];

endmodule

// File: tb/tb_piso_ser.sv
// Directed bench for piso_ser (WIDTH=8), with a 4-bit right shift register chained on so.
// Expectations follow PISO_PARITY_EN when it is defined for the build.
module tb_piso_ser;

`ifdef PISO_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int FL = PAR ? 9 : 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       so;
    logic       so_valid;
    logic       busy;
    logic [3:0] sr;

    int n_checks = 0;
    int n_fail   = 0;

    piso_ser #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .so        (so),
        .so_valid  (so_valid),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Downstream 4-bit right shift register fed from so.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr <= 4'h0;
        else     sr <= {so, sr[3:1]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-supplied parity p (even parity of w) is used only in the parity build.
    function automatic logic [8:0] fr(input logic [7:0] w, input logic p);
        return PAR ? {w, p} : {1'b0, w};
    endfunction

    task automatic expect_frame(input string tag, input logic [8:0] bits,
                                input int valid_from, input logic [7:0] next_din);
        for (int i = 0; i < FL; i++) begin
            if (i == valid_from) begin
                din       = next_din;
                din_valid = 1'b1;
            end
            check($sformatf("%s so[%0d]", tag, i), so, bits[FL-1-i]);
            check($sformatf("%s so_valid[%0d]", tag, i), so_valid, 1'b1);
            check($sformatf("%s busy[%0d]", tag, i), busy, 1'b1);
            check($sformatf("%s din_ready[%0d]", tag, i), din_ready, (i == FL - 1));
            step();
        end
    endtask

    task automatic expect_idle(input string tag);
        check({tag, " so"}, so, 1'b0);
        check({tag, " so_valid"}, so_valid, 1'b0);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " din_ready"}, din_ready, 1'b1);
    endtask

    task automatic accept(input logic [7:0] w);
        din       = w;
        din_valid = 1'b1;
        check("accept din_ready", din_ready, 1'b1);
        step();
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 expect_idle("reset_async");
        step();
        step();
        expect_idle("reset_held");
        rst = 1'b0;
        step();
        expect_idle("post_reset");

        // Single word; din is scrambled after acceptance to prove it is not resampled.
        accept(8'hCA);
        din_valid = 1'b0;
        din       = 8'h00;
        expect_frame("single", fr(8'hCA, 1'b0), -1, 8'h00);
        expect_idle("single_end");
        step();
        expect_idle("single_idle");

        // Back-to-back: 8'h35 offered with din_valid held throughout the first frame.
        accept(8'hCA);
        expect_frame("b2b_a", fr(8'hCA, 1'b0), 0, 8'h35);
        din_valid = 1'b0;
        din       = 8'h00;
        expect_frame("b2b_b", fr(8'h35, 1'b0), -1, 8'h00);
        expect_idle("b2b_end");

        // Stall: 8'hFF presented from cycle 2 must wait for the last-bit edge.
        accept(8'hCA);
        din_valid = 1'b0;
        expect_frame("stall", fr(8'hCA, 1'b0), 1, 8'hFF);
        din_valid = 1'b0;
        din       = 8'h00;
        expect_frame("stall_ff", fr(8'hFF, 1'b0), -1, 8'h00);
        expect_idle("stall_end");

        // Mid-frame reset during cycle 4, then a fresh 8'h81 frame.
        accept(8'hCA);
        din_valid = 1'b0;
        step();
        step();
        step();
        check("mrst pre so_valid", so_valid, 1'b1);
        check("mrst pre din_ready", din_ready, 1'b0);
        rst = 1'b1;
        #2 expect_idle("mrst_async");
        rst = 1'b0;
        accept(8'h81);
        din_valid = 1'b0;
        expect_frame("rst_81", fr(8'h81, 1'b0), -1, 8'h00);
        expect_idle("rst_81_end");

        // 8'h07 has odd weight, so its parity bit is 1 in the parity build.
        accept(8'h07);
        din_valid = 1'b0;
        expect_frame("w07", fr(8'h07, 1'b1), -1, 8'h00);
        expect_idle("w07_end");

        // Chained register: sr[0] replays the 8'hCA bits four cycles later.
        step();
        accept(8'hCA);
        din_valid = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c >= 5) begin
                check($sformatf("chain sr_so[c%0d]", c), sr[0], logic'((8'hCA >> (12 - c)) & 8'h01));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
